// File: rtl/hazard_pkg.sv
// Shared types for the hazard/forwarding unit: forwarding select encoding,
// FSM states and the EX/MEM destination-register shadow.
package hazard_pkg;

  localparam int REG_W = 5;

  typedef logic [1:0] fwd_sel_t;
  localparam fwd_sel_t FWD_RF    = 2'b00;
  localparam fwd_sel_t FWD_EXMEM = 2'b01;
  localparam fwd_sel_t FWD_MEMWB = 2'b10;

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic             wr;
    logic             load;
  } shadow_t;

  // x0 is hardwired to zero, so a write to it never produces a forward
  function automatic logic reg_match(input logic [REG_W-1:0] src, input logic used,
                                     input logic [REG_W-1:0] rd, input logic wr);
    return used & wr & (rd != '0) & (src == rd);
  endfunction

endpackage

// File: rtl/fwd_compare.sv
// Per-operand match against the EX and MEM shadows; EX wins over MEM because
// it holds the younger result.
module fwd_compare
  import hazard_pkg::*;
(
  input  logic [REG_W-1:0] src_i,
  input  logic             used_i,
  input  shadow_t          ex_i,
  input  shadow_t          mem_i,
  output fwd_sel_t         sel_o,
  output logic             ex_hit_o
);

  logic mem_hit;

  assign ex_hit_o = reg_match(src_i, used_i, ex_i.rd, ex_i.wr);
  assign mem_hit  = reg_match(src_i, used_i, mem_i.rd, mem_i.wr);

  always_comb begin
    sel_o = FWD_RF;
    if (ex_hit_o)     sel_o = FWD_EXMEM;
    else if (mem_hit) sel_o = FWD_MEMWB;
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard detection and forwarding-select generation beside the ID stage,
// with a saturating stall-cycle counter.
module hazard_fwd_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = REG_W,
  parameter int CNT_W      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  id_rs1_used_i,
  input  logic                  id_rs2_used_i,
  input  logic [REG_ADDR_W-1:0] id_rd_i,
  input  logic                  id_reg_write_i,
  input  logic                  id_mem_read_i,
  input  logic                  mem_req_i,
  input  logic                  mem_ready_i,
  input  logic                  ex_branch_taken_i,
  output logic [1:0]            fwd_a_o,
  output logic [1:0]            fwd_b_o,
  output logic                  pc_stall_o,
  output logic                  if_id_stall_o,
  output logic                  id_ex_bubble_o,
  output logic                  freeze_o,
  output logic                  flush_o,
  output logic [CNT_W-1:0]      stall_cnt_o
);

  state_t           state_q, state_d;
  shadow_t          ex_q, ex_d, mem_q, mem_d;
  fwd_sel_t         fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  fwd_sel_t         sel_a, sel_b;
  logic             hit_a, hit_b;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             freeze, flush, bubble, load_use;

  fwd_compare u_fwd_a (
    .src_i    (id_rs1_i),
    .used_i   (id_rs1_used_i),
    .ex_i     (ex_q),
    .mem_i    (mem_q),
    .sel_o    (sel_a),
    .ex_hit_o (hit_a)
  );

  fwd_compare u_fwd_b (
    .src_i    (id_rs2_i),
    .used_i   (id_rs2_used_i),
    .ex_i     (ex_q),
    .mem_i    (mem_q),
    .sel_o    (sel_b),
    .ex_hit_o (hit_b)
  );

  always_comb begin
    state_d  = state_q;
    freeze   = 1'b0;
    load_use = id_valid_i & ex_q.load & (hit_a | hit_b);
    case (state_q)
      ST_RUN: begin
        if (mem_req_i && !mem_ready_i) begin
          state_d = ST_MEM_WAIT;
          freeze  = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ready_i) state_d = ST_RUN;
        else             freeze  = 1'b1;
      end
      default: state_d = ST_RUN;
    endcase
    // a taken branch kills the stale ID instruction, so its load-use stall is moot
    flush  = ex_branch_taken_i & ~freeze;
    bubble = load_use & ~flush & ~freeze;
  end

  always_comb begin
    ex_d    = ex_q;
    mem_d   = mem_q;
    fwd_a_d = fwd_a_q;
    fwd_b_d = fwd_b_q;
    if (!freeze) begin
      mem_d = ex_q;
      if (flush || bubble) begin
        ex_d    = '0;
        fwd_a_d = FWD_RF;
        fwd_b_d = FWD_RF;
      end else begin
        ex_d.rd   = id_rd_i;
        ex_d.wr   = id_valid_i & id_reg_write_i;
        ex_d.load = id_valid_i & id_mem_read_i;
        fwd_a_d   = sel_a;
        fwd_b_d   = sel_b;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if ((freeze || bubble) && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
      ex_q    <= '0;
      mem_q   <= '0;
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
      cnt_q   <= cnt_d;
    end
  end

  // controls are combinational, so gate them to keep them low during reset
  assign freeze_o       = freeze & ~rst_i;
  assign flush_o        = flush & ~rst_i;
  assign id_ex_bubble_o = bubble & ~rst_i;
  assign if_id_stall_o  = bubble & ~rst_i;
  assign pc_stall_o     = (freeze | bubble) & ~rst_i;
  assign fwd_a_o        = fwd_a_q;
  assign fwd_b_o        = fwd_b_q;
  assign stall_cnt_o    = cnt_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed-vector bench for hazard_fwd_unit; expected values are hand-derived
// from the instruction sequences below.
module tb_hazard_fwd_unit;

  localparam int CW = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          id_valid_i;
  logic [4:0]    id_rs1_i, id_rs2_i, id_rd_i;
  logic          id_rs1_used_i, id_rs2_used_i;
  logic          id_reg_write_i, id_mem_read_i;
  logic          mem_req_i, mem_ready_i, ex_branch_taken_i;
  logic [1:0]    fwd_a_o, fwd_b_o;
  logic          pc_stall_o, if_id_stall_o, id_ex_bubble_o, freeze_o, flush_o;
  logic [CW-1:0] stall_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  hazard_fwd_unit #(.REG_ADDR_W(5), .CNT_W(CW)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .id_valid_i        (id_valid_i),
    .id_rs1_i          (id_rs1_i),
    .id_rs2_i          (id_rs2_i),
    .id_rs1_used_i     (id_rs1_used_i),
    .id_rs2_used_i     (id_rs2_used_i),
    .id_rd_i           (id_rd_i),
    .id_reg_write_i    (id_reg_write_i),
    .id_mem_read_i     (id_mem_read_i),
    .mem_req_i         (mem_req_i),
    .mem_ready_i       (mem_ready_i),
    .ex_branch_taken_i (ex_branch_taken_i),
    .fwd_a_o           (fwd_a_o),
    .fwd_b_o           (fwd_b_o),
    .pc_stall_o        (pc_stall_o),
    .if_id_stall_o     (if_id_stall_o),
    .id_ex_bubble_o    (id_ex_bubble_o),
    .freeze_o          (freeze_o),
    .flush_o           (flush_o),
    .stall_cnt_o       (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic id_set(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic rw, input logic mr);
    id_valid_i     = v;
    id_rs1_i       = r1;
    id_rs2_i       = r2;
    id_rs1_used_i  = u1;
    id_rs2_used_i  = u2;
    id_rd_i        = rd;
    id_reg_write_i = rw;
    id_mem_read_i  = mr;
  endtask

  task automatic id_nop;
    id_set(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1;
    id_nop();
    mem_req_i = 1'b1;
    mem_ready_i = 1'b0;
    ex_branch_taken_i = 1'b1;
    #2;
    check("rst_freeze", 32'(freeze_o), 32'd0);
    check("rst_flush", 32'(flush_o), 32'd0);
    check("rst_pc_stall", 32'(pc_stall_o), 32'd0);
    check("rst_fwd_a", 32'(fwd_a_o), 32'd0);
    check("rst_fwd_b", 32'(fwd_b_o), 32'd0);
    check("rst_cnt", 32'(stall_cnt_o), 32'd0);
    mem_req_i = 1'b0;
    ex_branch_taken_i = 1'b0;
    #20;
    rst_i = 1'b0;
    tick();

    // add x5,x1,x2 ; sub x6,x5,x3
    id_set(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0);
    tick();
    id_set(1, 5'd5, 5'd3, 1, 1, 5'd6, 1, 0);
    #1;
    check("t1_no_bubble", 32'(id_ex_bubble_o), 32'd0);
    tick();
    check("t1_fwd_a", 32'(fwd_a_o), 32'h1);
    check("t1_fwd_b", 32'(fwd_b_o), 32'h0);

    // add x5 ; nop ; or x7,x4,x5
    id_set(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0);
    tick();
    id_nop();
    tick();
    id_set(1, 5'd4, 5'd5, 1, 1, 5'd7, 1, 0);
    tick();
    check("t2_fwd_a", 32'(fwd_a_o), 32'h0);
    check("t2_fwd_b", 32'(fwd_b_o), 32'h2);
    check("t2_cnt", 32'(stall_cnt_o), 32'd0);

    // lw x8,0(x1) ; add x9,x8,x8
    id_set(1, 5'd1, 5'd0, 1, 0, 5'd8, 1, 1);
    tick();
    id_set(1, 5'd8, 5'd8, 1, 1, 5'd9, 1, 0);
    #1;
    check("t3_bubble", 32'(id_ex_bubble_o), 32'd1);
    check("t3_pc_stall", 32'(pc_stall_o), 32'd1);
    check("t3_if_id_stall", 32'(if_id_stall_o), 32'd1);
    check("t3_flush", 32'(flush_o), 32'd0);
    tick();
    check("t3_bubble_fwd_a", 32'(fwd_a_o), 32'h0);
    check("t3_bubble_once", 32'(id_ex_bubble_o), 32'd0);
    check("t3_cnt", 32'(stall_cnt_o), 32'd1);
    tick();
    check("t3_fwd_a", 32'(fwd_a_o), 32'h2);
    check("t3_fwd_b", 32'(fwd_b_o), 32'h2);

    // add x0,x1,x2 ; add x3,x0,x0
    id_set(1, 5'd1, 5'd2, 1, 1, 5'd0, 1, 0);
    tick();
    id_set(1, 5'd0, 5'd0, 1, 1, 5'd3, 1, 0);
    tick();
    check("t4_fwd_a_x0", 32'(fwd_a_o), 32'h0);
    check("t4_fwd_b_x0", 32'(fwd_b_o), 32'h0);

    // three-cycle data-memory wait with add x10,x3,x4 held in ID
    id_set(1, 5'd3, 5'd4, 1, 1, 5'd10, 1, 0);
    mem_req_i = 1'b1;
    mem_ready_i = 1'b0;
    #1;
    check("t5_freeze_c0", 32'(freeze_o), 32'd1);
    tick();
    check("t5_freeze_c1", 32'(freeze_o), 32'd1);
    check("t5_pc_stall_c1", 32'(pc_stall_o), 32'd1);
    check("t5_fwd_hold", 32'(fwd_a_o), 32'h0);
    tick();
    check("t5_freeze_c2", 32'(freeze_o), 32'd1);
    tick();
    mem_ready_i = 1'b1;
    #1;
    check("t5_unfreeze", 32'(freeze_o), 32'd0);
    check("t5_cnt", 32'(stall_cnt_o), 32'd4);
    tick();
    mem_req_i = 1'b0;
    mem_ready_i = 1'b0;
    check("t5_resume_fwd_a", 32'(fwd_a_o), 32'h1);
    check("t5_cnt_after", 32'(stall_cnt_o), 32'd4);

    // lw x11 ; add x12,x11,x0 with a taken branch in EX
    id_set(1, 5'd1, 5'd0, 1, 0, 5'd11, 1, 1);
    tick();
    id_set(1, 5'd11, 5'd0, 1, 1, 5'd12, 1, 0);
    ex_branch_taken_i = 1'b1;
    #1;
    check("t6_flush", 32'(flush_o), 32'd1);
    check("t6_no_bubble", 32'(id_ex_bubble_o), 32'd0);
    check("t6_no_pc_stall", 32'(pc_stall_o), 32'd0);
    tick();
    ex_branch_taken_i = 1'b0;
    check("t6_fwd_a", 32'(fwd_a_o), 32'h0);
    check("t6_cnt", 32'(stall_cnt_o), 32'd4);

    // reset pulse while in MEM_WAIT
    id_set(1, 5'd1, 5'd2, 1, 1, 5'd13, 1, 0);
    tick();
    id_set(1, 5'd13, 5'd0, 1, 1, 5'd14, 1, 0);
    tick();
    check("t7_fwd_a_pre", 32'(fwd_a_o), 32'h1);
    id_nop();
    mem_req_i = 1'b1;
    mem_ready_i = 1'b0;
    tick();
    check("t7_freeze_wait", 32'(freeze_o), 32'd1);
    check("t7_fwd_a_hold", 32'(fwd_a_o), 32'h1);
    #2;
    rst_i = 1'b1;
    #1;
    check("t7_rst_freeze", 32'(freeze_o), 32'd0);
    check("t7_rst_pc_stall", 32'(pc_stall_o), 32'd0);
    check("t7_rst_fwd_a", 32'(fwd_a_o), 32'h0);
    check("t7_rst_cnt", 32'(stall_cnt_o), 32'd0);
    mem_req_i = 1'b0;
    #2;
    rst_i = 1'b0;
    #1;
    check("t7_run_after_rst", 32'(freeze_o), 32'd0);
    tick();
    check("t7_run_next", 32'(freeze_o), 32'd0);

    // counter saturation (4-bit counter, 17 frozen cycles)
    mem_req_i = 1'b1;
    mem_ready_i = 1'b0;
    repeat (17) tick();
    check("t8_cnt_sat", 32'(stall_cnt_o), 32'd15);
    tick();
    check("t8_cnt_hold", 32'(stall_cnt_o), 32'd15);
    mem_ready_i = 1'b1;
    tick();
    mem_req_i = 1'b0;
    mem_ready_i = 1'b0;
    tick();
    check("t8_freeze_off", 32'(freeze_o), 32'd0);
    check("t8_cnt_final", 32'(stall_cnt_o), 32'd15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_unit.md
Name: hazard_fwd_unit

Overview:
- Pipeline control block for the RISC-V lite core, sitting beside the ID stage. It produces the forwarding selects consumed by the EX-stage operand muxes, so it is the producer end of the sel_f encoding.
- Keeps a shadow of the destination registers of the instructions in EX and MEM.
- Detects load-use hazards and data-memory wait states, and drives stall, bubble and flush controls.
- Keeps a saturating stall-cycle counter for performance measurement.

Parameters:
- REG_ADDR_W, 5, register index width.
- CNT_W, 16, stall counter width.

Ports:
- clk_i  in  1  core clock.
- rst_i  in  1  asynchronous active-high reset.
- id_valid_i  in  1  ID holds a real instruction.
- id_rs1_i  in  REG_ADDR_W  rs1 index of the ID instruction.
- id_rs2_i  in  REG_ADDR_W  rs2 index of the ID instruction.
- id_rs1_used_i  in  1  ID instruction reads rs1.
- id_rs2_used_i  in  1  ID instruction reads rs2.
- id_rd_i  in  REG_ADDR_W  rd index of the ID instruction.
- id_reg_write_i  in  1  ID instruction writes rd.
- id_mem_read_i  in  1  ID instruction is a load.
- mem_req_i  in  1  MEM stage has an outstanding data access.
- mem_ready_i  in  1  data memory completes the access this cycle.
- ex_branch_taken_i  in  1  taken branch/jump resolved in EX.
- fwd_a_o  out  2  registered operand-A select for EX: 00 regfile, 01 EX-MEM, 10 MEM-WB; 11 never driven.
- fwd_b_o  out  2  registered operand-B select for EX, same encoding.
- pc_stall_o  out  1  hold PC.
- if_id_stall_o  out  1  hold the IF/ID register.
- id_ex_bubble_o  out  1  load a NOP into ID/EX.
- freeze_o  out  1  hold every pipeline register.
- flush_o  out  1  clear IF/ID and ID/EX.
- stall_cnt_o  out  CNT_W  saturating count of stall cycles.

Behaviour:
Reset:
- All shadow state cleared; the FSM enters RUN.
- fwd_a_o/fwd_b_o = 00; stall_cnt_o = 0.
- All control outputs are 0 while rst_i is high, and a reset asserted mid-operation takes effect immediately.

Shadow registers:
- The shadow holds ex_rd, ex_wr, ex_load, mem_rd and mem_wr.
- On an advance cycle (no freeze, no bubble, no flush), EX shadow ← ID fields qualified by id_valid_i, and MEM shadow ← EX shadow.
- On a bubble or flush, the EX shadow is cleared (wr=0, load=0) and MEM still advances.
- On freeze, all shadow state holds.

Match rule:
- match(src, rd, wr) = used & wr & (rd != 0) & (src == rd).
- Register x0 is never forwarded.

Forward compute:
- For each operand: if match against EX then sel = 01; else if match against MEM then sel = 10; else sel = 00. EX has priority over MEM.
- The result is registered into fwd_x_o on advance cycles.
- On a bubble or flush, 00 is registered.
- On freeze, the output holds.
- The register file is write-before-read, so no WB-to-ID bypass is needed.

FSM states:
- RUN: freeze_o=0.
  - If (rs1 or rs2 match EX) & ex_load & id_valid_i and no flush: pc_stall_o = if_id_stall_o = id_ex_bubble_o = 1 for exactly this cycle. The load then advances to MEM, the next ID compare matches MEM and yields 10.
  - If mem_req_i & !mem_ready_i: go to MEM_WAIT with freeze_o=1 combinationally in the same cycle.
- MEM_WAIT: freeze_o=1 and pc_stall_o=1; return to RUN in the cycle mem_ready_i=1. freeze_o is deasserted combinationally in that cycle.

Priority:
- Freeze > flush > load-use.
- During freeze, flush and bubble are suppressed; ex_branch_taken_i is held by the frozen EX stage and acts on the first unfrozen cycle.
- Flush together with load-use: flush_o=1, no bubble. The stale ID instruction is killed, so the stall is dropped.

Counter:
- stall_cnt_o increments on every cycle where freeze_o or id_ex_bubble_o is 1.
- Saturates at 2^CNT_W−1 and never wraps.

Latency:
- Control outputs are combinational from inputs and state.
- Forwarding selects appear one cycle after the instruction leaves ID, aligned with its EX cycle.

Decomposition:
- Package hazard_pkg holds:
  - typedef fwd_sel_t (2 bits) with constants FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10;
  - the FSM state enum {ST_RUN, ST_MEM_WAIT};
  - the shadow struct {rd, wr, load}.
- One sub-module, fwd_compare: a combinational match and priority select per operand, instantiated twice (A and B).

Test Plan:
- add x5,x1,x2 followed by sub x6,x5,x3 → fwd_a_o=01 during the sub EX cycle; fwd_b_o=00; no stall.
- add x5 ; nop ; or x7,x4,x5 → fwd_b_o=10; stall_cnt_o unchanged.
- lw x8,0(x1) ; add x9,x8,x8 → exactly one cycle of id_ex_bubble_o=1 / pc_stall_o=1, then fwd_a_o=fwd_b_o=10; stall_cnt_o=1.
- add x0,x1,x2 ; add x3,x0,x0 → fwd selects 00 (x0 never forwarded).
- mem_req_i=1 with mem_ready_i=0 for 3 cycles → freeze_o=1 for 3 cycles; fwd outputs and shadow hold; stall_cnt_o +3; resume on ready.
- Load-use hazard concurrent with ex_branch_taken_i=1 → flush_o=1, id_ex_bubble_o=0.
- rst_i pulsed mid-MEM_WAIT → all outputs return to 0 asynchronously and the FSM is in RUN after release.
- Force the counter to max → it stays saturated.
